// File: rtl/fpmac_dot_engine.sv
// Sequenced floating-point dot-product engine: acc += numA*numB over LEN terms, one term per 5 cycles.
// Truncating arithmetic, denormals flushed to zero, Inf is sticky in the accumulator, ovf/unf are sticky.
module fpmac_dot_engine #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int LEN   = 8,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   Asynch_Reset_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   numA,
    input  logic [EXP_W+MAN_W:0]   numB,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   acc_result,
    output logic [CNT_W-1:0]       acc_count,
    output logic                   busy,
    output logic                   ovf,
    output logic                   unf
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int XW   = EXP_W + $clog2(MAN_W + 2) + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic [EXP_W-1:0]     EMAX   = '1;
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);

    typedef enum logic [2:0] {IDLE, ACCEPT, MUL1, MUL2, ADD1, ADD2, DONE} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d;
    logic                 m_sign_q, m_sign_d, m_inf_q, m_inf_d, m_zero_q, m_zero_d;
    logic signed [XW-1:0] m_exp_q, m_exp_d;
    logic [PW-1:0]        m_prod_q, m_prod_d;
    logic [W-1:0]         p_q, p_d;
    logic                 p_unf_q, p_unf_d;
    logic                 s_sign_q, s_sign_d, s_inf_q, s_inf_d;
    logic signed [XW-1:0] s_exp_q, s_exp_d;
    logic [SW:0]          s_raw_q, s_raw_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;

    logic [EXP_W-1:0]     pe, ae, e_big, e_small, e_diff;
    logic [SW-1:0]        p_sig, a_sig, sig_big, sig_small, sig_al;
    logic                 p_big, sign_big, p_inf, a_inf;
    logic signed [XW-1:0] n_exp, r_exp;
    logic [MAN_W-1:0]     n_frac, r_frac;
    logic [W-1:0]         r_val;
    logic                 r_inf, r_unf;
    int                   lead;

    always_comb begin
        m_sign_d = a_q[W-1] ^ b_q[W-1];
        m_inf_d  = (a_q[W-2:MAN_W] == EMAX) || (b_q[W-2:MAN_W] == EMAX);
        m_zero_d = (a_q[W-2:MAN_W] == '0) || (b_q[W-2:MAN_W] == '0);
        m_exp_d  = XW'(a_q[W-2:MAN_W]) + XW'(b_q[W-2:MAN_W]) - BIAS_X;
        m_prod_d = PW'({1'b1, a_q[MAN_W-1:0]}) * PW'({1'b1, b_q[MAN_W-1:0]});

        // Product significand lies in [1,4); a set top bit means one extra binade.
        if (m_prod_q[PW-1]) begin
            n_exp  = m_exp_q + ONE_X;
            n_frac = MAN_W'(m_prod_q >> (MAN_W + 1));
        end else begin
            n_exp  = m_exp_q;
            n_frac = MAN_W'(m_prod_q >> MAN_W);
        end
        p_d     = '0;
        p_unf_d = 1'b0;
        if (m_inf_q || n_exp >= EMAX_X) begin
            p_d = {m_sign_q, EMAX, {MAN_W{1'b0}}};
        end else if (!m_zero_q) begin
            if (n_exp < ONE_X) p_unf_d = 1'b1;
            else               p_d = {m_sign_q, n_exp[EXP_W-1:0], n_frac};
        end

        pe        = p_q[W-2:MAN_W];
        ae        = acc_q[W-2:MAN_W];
        p_inf     = (pe == EMAX);
        a_inf     = (ae == EMAX);
        p_sig     = (pe != '0) ? {1'b1, p_q[MAN_W-1:0]} : '0;
        a_sig     = (ae != '0) ? {1'b1, acc_q[MAN_W-1:0]} : '0;
        p_big     = (p_q[W-2:0] >= acc_q[W-2:0]);
        sign_big  = p_big ? p_q[W-1] : acc_q[W-1];
        e_big     = p_big ? pe : ae;
        e_small   = p_big ? ae : pe;
        sig_big   = p_big ? p_sig : a_sig;
        sig_small = p_big ? a_sig : p_sig;
        e_diff    = e_big - e_small;
        sig_al    = (int'(e_diff) >= MAN_W + 2) ? '0 : (sig_small >> e_diff);
        s_raw_d   = (p_q[W-1] == acc_q[W-1]) ? ({1'b0, sig_big} + {1'b0, sig_al})
                                             : ({1'b0, sig_big} - {1'b0, sig_al});
        s_exp_d   = XW'(e_big);
        s_inf_d   = p_inf || a_inf;
        // Opposite infinities resolve to +Inf, which the AND of the two signs gives directly.
        if (p_inf && a_inf) s_sign_d = p_q[W-1] & acc_q[W-1];
        else if (p_inf)     s_sign_d = p_q[W-1];
        else if (a_inf)     s_sign_d = acc_q[W-1];
        else                s_sign_d = sign_big;

        lead = 0;
        for (int i = 0; i <= SW; i++) begin
            if (s_raw_q[i]) lead = i;
        end
        if (lead > MAN_W) begin
            r_exp  = s_exp_q + ONE_X;
            r_frac = MAN_W'(s_raw_q >> 1);
        end else begin
            r_exp  = s_exp_q - XW'(MAN_W - lead);
            r_frac = MAN_W'(s_raw_q << (MAN_W - lead));
        end
        r_val = '0;
        r_inf = 1'b0;
        r_unf = 1'b0;
        if (s_inf_q || (s_raw_q != '0 && r_exp >= EMAX_X)) begin
            r_val = {s_sign_q, EMAX, {MAN_W{1'b0}}};
            r_inf = 1'b1;
        end else if (s_raw_q != '0) begin
            if (r_exp < ONE_X) r_unf = 1'b1;
            else               r_val = {s_sign_q, r_exp[EXP_W-1:0], r_frac};
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (in_valid) begin
                    a_d     = numA;
                    b_d     = numB;
                    state_d = MUL1;
                end
            end
            MUL1: state_d = MUL2;
            MUL2: state_d = ADD1;
            ADD1: state_d = ADD2;
            ADD2: begin
                acc_d = r_val;
                if (int'(cnt_q) < LEN) cnt_d = cnt_q + CNT_W'(1);
                ovf_d   = ovf_q | r_inf;
                unf_d   = unf_q | p_unf_q | r_unf;
                state_d = (int'(cnt_q) + 1 >= LEN) ? DONE : ACCEPT;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge Asynch_Reset_n) begin
        if (!Asynch_Reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_sign_q <= 1'b0;
            m_inf_q  <= 1'b0;
            m_zero_q <= 1'b0;
            m_exp_q  <= '0;
            m_prod_q <= '0;
            p_q      <= '0;
            p_unf_q  <= 1'b0;
            s_sign_q <= 1'b0;
            s_inf_q  <= 1'b0;
            s_exp_q  <= '0;
            s_raw_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_sign_q <= m_sign_d;
            m_inf_q  <= m_inf_d;
            m_zero_q <= m_zero_d;
            m_exp_q  <= m_exp_d;
            m_prod_q <= m_prod_d;
            p_q      <= p_d;
            p_unf_q  <= p_unf_d;
            s_sign_q <= s_sign_d;
            s_inf_q  <= s_inf_d;
            s_exp_q  <= s_exp_d;
            s_raw_q  <= s_raw_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign in_ready   = (state_q == ACCEPT);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign acc_result = acc_q;
    assign acc_count  = cnt_q;
    assign ovf        = ovf_q;
    assign unf        = unf_q;
endmodule

// File: doc/fpmac_dot_engine.md
Name: fpmac_dot_engine

Overview:
Parametrised successor to the half-precision pipelined FP MAC. Computes a LEN-term floating-point dot product (sum of numA*numB) with configurable exponent/mantissa widths, a start command, valid/ready input and output handshakes, and sticky exception flags. It sits between the operand source and result consumer in the FPMAC system. The accumulator feedback hazard is handled by a sequencing FSM, not free-running.

Parameters:
EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 10, stored mantissa width (hidden 1 implied)
LEN, 8, products per dot product (>=1)
CNT_W, 4, width of term counter (2^CNT_W > LEN)

Ports:
clk  in  1  rising-edge clock
Asynch_Reset_n  in  1  asynchronous active-low reset
start  in  1  begin new dot product (honoured in IDLE only)
in_valid  in  1  operand pair valid
in_ready  out  1  engine accepts operands this cycle
numA  in  1+EXP_W+MAN_W  operand A {sign,exp,man}
numB  in  1+EXP_W+MAN_W  operand B
out_valid  out  1  acc_result holds final sum
out_ready  in  1  consumer takes result
acc_result  out  1+EXP_W+MAN_W  running/final accumulator
acc_count  out  CNT_W  terms accumulated so far
busy  out  1  high outside IDLE
ovf  out  1  sticky: overflow/Inf occurred this dot product
unf  out  1  sticky: nonzero result flushed to zero

Behaviour:
- Reset (Asynch_Reset_n low, async assert, sync release): state IDLE; acc_result=0, acc_count=0, in_ready=0, out_valid=0, busy=0, ovf=0, unf=0; all pipeline registers 0. Reset mid-operation aborts the dot product; no partial result emitted.
- States: IDLE, ACCEPT, MUL1, MUL2, ADD1, ADD2, DONE.
- IDLE: start=1 -> clear acc_result, acc_count, ovf, unf; go ACCEPT. start ignored in other states.
- ACCEPT: in_ready=1. in_valid&in_ready -> register operands, go MUL1. No transfer -> stay.
- MUL1: sign XOR, exponent sum minus bias, (MAN_W+1)x(MAN_W+1) mantissa product registered.
- MUL2: normalise product (shift 1 if MSB of 2*(MAN_W+1)-bit product set, exponent+1), truncate to MAN_W; registered as product.
- ADD1: align smaller-magnitude operand (product vs acc_result) by exponent difference (shift >= MAN_W+2 yields 0), add/subtract by signs, register raw sum, sign, exponent.
- ADD2: leading-one normalise, truncate, write acc_result, acc_count+1. If acc_count+1==LEN go DONE, else ACCEPT.
- Per-term latency: 4 cycles from accept to acc_result update; in_ready reasserts the cycle after ADD2. Throughput one term / 5 cycles.
- DONE: out_valid=1, acc_result stable; out_valid&out_ready -> IDLE (acc_result held until next start). out_valid not dropped without out_ready.
- Arithmetic rules: exp field 0 = zero (denormals flushed, input and output); rounding = truncation; exact-zero sum = +0; any operand with exp all-ones or exponent overflow -> result +/-Inf (exp all-ones, man 0), ovf=1; Inf persists in accumulator (Inf + finite = Inf; +Inf + -Inf = +Inf, ovf=1). Product/sum exponent below 1 -> signed zero forced to +0, unf=1 if true value nonzero.
- busy=1 in every state except IDLE. acc_count saturates at LEN.

Test Plan:
- Reset then start, LEN=4, A={0x3C00,0x4000,0x4200,0xBC00}, B={0x4000,0x4000,0x3800,0x3C00} -> out_valid after 4th ADD2, acc_result=0x4680 (6.5), acc_count=4, ovf=unf=0.
- LEN=2, (0x4200*0x3C00)+(0xC200*0x3C00) -> acc_result=0x0000, no flags.
- 0x7BFF*0x7BFF as first term -> acc_result=0x7C00, ovf=1, persists to DONE.
- 0x0400*0x3800 -> acc_result=0x0000, unf=1.
- in_valid held high, check in_ready high only in ACCEPT (1 cycle in 5); out_ready low 10 cycles in DONE -> out_valid and acc_result hold; start during busy ignored.
- Assert Asynch_Reset_n low during ADD1 of term 2 -> all outputs 0 immediately; new start completes correctly.
